// File: rtl/cas_fsk_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : cas_fsk_player_if
//  Description : Item handshake between the cassette image loader (master)
//                and the FSK player (slave).
//                  in_valid  master->slave  item valid
//                  in_ready  slave->master  player accepts an item this edge
//                  in_hdr    master->slave  1 = header item, 0 = data byte
//                  in_data   master->slave  byte / header kind in bit 0
//                  turbo     master->slave  2400-baud select (CAS_TURBO_EN only)
//  Options     : CAS_TURBO_EN adds the turbo signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cas_fsk_player_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_hdr;
  logic [7:0] in_data;
`ifdef CAS_TURBO_EN
  logic       turbo;

  modport master (output in_valid, in_hdr, in_data, turbo, input in_ready);
  modport slave  (input in_valid, in_hdr, in_data, turbo, output in_ready);
`else
  modport master (output in_valid, in_hdr, in_data, input in_ready);
  modport slave  (input in_valid, in_hdr, in_data, output in_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/cas_fsk_player.sv
`default_nettype none
// ============================================================================
//  Module      : cas_fsk_player
//  Description : MSX 1200-baud cassette FSK transmitter. Converts loader
//                items (data bytes, long/short headers) into the audio level
//                sampled by the cassette input. Playback freezes while the
//                motor line is low and resumes at the exact same phase.
//  Ports       : clk       system clock
//                reset     asynchronous active-high reset
//                motor     cassette motor (1 = run)
//                bus       item handshake (slave side)
//                cas_audio FSK audio level
//                busy      item in progress (also while paused)
//  Options     : CAS_TURBO_EN - items taken with turbo=1 use HALF_DIV/2.
//  Revision    : 1.0 - initial release
// ============================================================================
module cas_fsk_player #(
  parameter int HALF_DIV   = 4474,
  parameter int SIL_HALVES = 4800,
  parameter int LONG_CYC   = 16000,
  parameter int SHORT_CYC  = 4000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       motor,
  cas_fsk_player_if.slave bus,
  output logic            cas_audio,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SILENCE = 2'd1,
    ST_HEADER  = 2'd2,
    ST_DATA    = 2'd3
  } state_t;

  localparam logic [14:0] c_HALF       = 15'(HALF_DIV);
  localparam logic [15:0] c_SIL_LAST   = 16'(SIL_HALVES - 1);
  localparam logic [15:0] c_LONG_LAST  = 16'(2 * LONG_CYC - 1);
  localparam logic [15:0] c_SHORT_LAST = 16'(2 * SHORT_CYC - 1);

  state_t      r_state,    w_state_nx;
  logic [14:0] r_half_cnt, w_half_cnt_nx;
  logic [14:0] r_half_len, w_half_len_nx;
  logic [15:0] r_cyc_cnt,  w_cyc_cnt_nx;
  logic [3:0]  r_bit_idx,  w_bit_idx_nx;
  logic [10:0] r_frame,    w_frame_nx;
  logic [14:0] w_sel_len;
  logic [14:0] w_reload;
  logic        w_xfer;
  logic        w_half_end;
  logic        w_level;

`ifdef CAS_TURBO_EN
  localparam logic [14:0] c_HALF_TURBO = 15'(HALF_DIV / 2);
  assign w_sel_len = bus.turbo ? c_HALF_TURBO : c_HALF;
`else
  assign w_sel_len = c_HALF;
`endif

  assign bus.in_ready = (r_state == ST_IDLE) & motor;
  assign w_xfer       = bus.in_valid & bus.in_ready;
  assign w_half_end   = (r_half_cnt == 15'd0);
  assign w_reload     = r_half_len - 15'd1;
  assign busy         = (r_state != ST_IDLE);
  // The level is frozen with the counters; motor low only masks it.
  assign cas_audio    = motor & w_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= 15'd0;
      r_half_len <= 15'd0;
      r_cyc_cnt  <= 16'd0;
      r_bit_idx  <= 4'd0;
      r_frame    <= 11'd0;
    end else begin
      r_state    <= w_state_nx;
      r_half_cnt <= w_half_cnt_nx;
      r_half_len <= w_half_len_nx;
      r_cyc_cnt  <= w_cyc_cnt_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_frame    <= w_frame_nx;
    end
  end

  // r_cyc_cnt meaning per state:
  //   SILENCE : silent halves remaining after the current one
  //   HEADER  : tone halves remaining after the current one (odd = high half)
  //   DATA    : quarter (half-period) index 0..3 inside the current bit
  always_comb begin
    w_state_nx    = r_state;
    w_half_cnt_nx = r_half_cnt;
    w_half_len_nx = r_half_len;
    w_cyc_cnt_nx  = r_cyc_cnt;
    w_bit_idx_nx  = r_bit_idx;
    w_frame_nx    = r_frame;
    w_level       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_half_len_nx = w_sel_len;
          w_half_cnt_nx = w_sel_len - 15'd1;
          w_bit_idx_nx  = 4'd0;
          if (!bus.in_hdr) begin
            // start bit, LSB-first data, two stop bits; bit 0 shifts out first
            w_frame_nx   = {2'b11, bus.in_data, 1'b0};
            w_cyc_cnt_nx = 16'd0;
            w_state_nx   = ST_DATA;
          end else if (bus.in_data[0]) begin
            w_cyc_cnt_nx = c_SIL_LAST;
            w_state_nx   = ST_SILENCE;
          end else begin
            w_cyc_cnt_nx = c_SHORT_LAST;
            w_state_nx   = ST_HEADER;
          end
        end
      end

      ST_SILENCE: begin
        if (motor) begin
          if (w_half_end) begin
            w_half_cnt_nx = w_reload;
            if (r_cyc_cnt == 16'd0) begin
              w_cyc_cnt_nx = c_LONG_LAST;
              w_state_nx   = ST_HEADER;
            end else begin
              w_cyc_cnt_nx = r_cyc_cnt - 16'd1;
            end
          end else begin
            w_half_cnt_nx = r_half_cnt - 15'd1;
          end
        end
      end

      ST_HEADER: begin
        w_level = r_cyc_cnt[0];
        if (motor) begin
          if (w_half_end) begin
            w_half_cnt_nx = w_reload;
            if (r_cyc_cnt == 16'd0) begin
              w_state_nx = ST_IDLE;
            end else begin
              w_cyc_cnt_nx = r_cyc_cnt - 16'd1;
            end
          end else begin
            w_half_cnt_nx = r_half_cnt - 15'd1;
          end
        end
      end

      ST_DATA: begin
        // 1 bit: H/L/H/L quarters; 0 bit: H/H/L/L quarters
        w_level = r_frame[0] ? ~r_cyc_cnt[0] : ~r_cyc_cnt[1];
        if (motor) begin
          if (w_half_end) begin
            w_half_cnt_nx = w_reload;
            if (r_cyc_cnt[1:0] == 2'd3) begin
              w_cyc_cnt_nx = 16'd0;
              if (r_bit_idx == 4'd10) begin
                w_state_nx = ST_IDLE;
              end else begin
                w_bit_idx_nx = r_bit_idx + 4'd1;
                w_frame_nx   = {1'b0, r_frame[10:1]};
              end
            end else begin
              w_cyc_cnt_nx = r_cyc_cnt + 16'd1;
            end
          end else begin
            w_half_cnt_nx = r_half_cnt - 15'd1;
          end
        end
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cas_fsk_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cas_fsk_player
//  Description : Self-checking bench for cas_fsk_player. A waveform model
//                expands each accepted item into its expected per-clock
//                audio levels and is stepped alongside the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cas_fsk_player;

  localparam int HD = 4;
  localparam int SH = 6;
  localparam int LC = 3;
  localparam int SC = 2;

  logic clk;
  logic rst;
  logic motor;
  logic cas_audio;
  logic busy;
  logic t_turbo;

  cas_fsk_player_if bus ();

`ifdef CAS_TURBO_EN
  assign bus.turbo = t_turbo;
`endif

  cas_fsk_player #(
    .HALF_DIV   (HD),
    .SIL_HALVES (SH),
    .LONG_CYC   (LC),
    .SHORT_CYC  (SC)
  ) u_dut (
    .clk       (clk),
    .reset     (rst),
    .motor     (motor),
    .bus       (bus),
    .cas_audio (cas_audio),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // waveform model
  bit mq[$];
  bit m_busy = 0;

  // values sampled at the last tick
  logic s_busy, s_ready, s_audio;

  typedef struct {
    bit         hdr;
    logic [7:0] data;
    bit         turbo;
    int         exp_cycles;
  } vec_t;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit eff_turbo();
`ifdef CAS_TURBO_EN
    return t_turbo;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_lv(bit lv, int n);
    repeat (n) mq.push_back(lv);
  endtask

  // Expand an item into the audio level of every clock it occupies.
  task automatic build(bit hdr, logic [7:0] d, bit tu);
    int h;
    int n;
    bit v;
    h = tu ? HD / 2 : HD;
    if (!hdr) begin
      for (int b = 0; b < 11; b++) begin
        if (b == 0)     v = 1'b0;
        else if (b > 8) v = 1'b1;
        else            v = d[b-1];
        if (v) begin
          push_lv(1, h); push_lv(0, h); push_lv(1, h); push_lv(0, h);
        end else begin
          push_lv(1, 2 * h); push_lv(0, 2 * h);
        end
      end
    end else begin
      n = d[0] ? LC : SC;
      if (d[0]) push_lv(0, SH * h);
      repeat (n) begin
        push_lv(1, h); push_lv(0, h);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven: check outputs,
  // advance the model across the next rising edge, return at the next fall.
  task automatic tick();
    bit e_aud;
    #1;
    s_busy  = busy;
    s_ready = bus.in_ready;
    s_audio = cas_audio;
    e_aud   = (m_busy && motor) ? mq[0] : 1'b0;
    chk("busy",      int'(s_busy),  int'(m_busy));
    chk("in_ready",  int'(s_ready), int'(!m_busy && motor));
    chk("cas_audio", int'(s_audio), int'(e_aud));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_busy = 0;
    end else if (motor) begin
      if (m_busy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_busy = 0;
      end else if (bus.in_valid) begin
        build(bus.in_hdr, bus.in_data, eff_turbo());
        m_busy = 1;
      end
    end
    @(negedge clk);
  endtask

  // Send one item and count the clocks busy stays high afterwards.
  task automatic run_item(bit hdr, logic [7:0] d, bit tu, output int n);
    bus.in_hdr   = hdr;
    bus.in_data  = d;
    t_turbo      = tu;
    bus.in_valid = 1'b1;
    tick();
    chk("xfer_ready", int'(s_ready), 1);
    bus.in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (!s_busy) break;
      n++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int n, n1, n2, idle;

    vecs.push_back('{hdr: 1'b0, data: 8'h00, turbo: 1'b0, exp_cycles: 176});
    vecs.push_back('{hdr: 1'b0, data: 8'hA5, turbo: 1'b0, exp_cycles: 176});
    vecs.push_back('{hdr: 1'b0, data: 8'hFF, turbo: 1'b0, exp_cycles: 176});
    vecs.push_back('{hdr: 1'b1, data: 8'h01, turbo: 1'b0, exp_cycles: 48});
    vecs.push_back('{hdr: 1'b1, data: 8'h00, turbo: 1'b0, exp_cycles: 16});
    vecs.push_back('{hdr: 1'b1, data: 8'hFE, turbo: 1'b0, exp_cycles: 16});
    vecs.push_back('{hdr: 1'b1, data: 8'h03, turbo: 1'b0, exp_cycles: 48});
    vecs.push_back('{hdr: 1'b0, data: 8'h3C, turbo: 1'b0, exp_cycles: 176});
`ifdef CAS_TURBO_EN
    vecs.push_back('{hdr: 1'b0, data: 8'h00, turbo: 1'b1, exp_cycles: 88});
    vecs.push_back('{hdr: 1'b1, data: 8'h01, turbo: 1'b1, exp_cycles: 24});
`endif

    rst          = 1'b1;
    motor        = 1'b0;
    t_turbo      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_hdr   = 1'b0;
    bus.in_data  = 8'h00;

    // reset state, motor off then on
    @(negedge clk);
    #1;
    chk("rst_busy",        int'(busy),         0);
    chk("rst_audio",       int'(cas_audio),    0);
    chk("rst_ready_motor0", int'(bus.in_ready), 0);
    motor = 1'b1;
    #1;
    chk("rst_ready_motor1", int'(bus.in_ready), 1);
    tick();
    rst = 1'b0;
    tick();

    // table-driven items
    foreach (vecs[i]) begin
      run_item(vecs[i].hdr, vecs[i].data, vecs[i].turbo, n);
      chk($sformatf("dur_vec%0d", i), n, vecs[i].exp_cycles);
    end
    t_turbo = 1'b0;

    // back-to-back 0xA5 then 0xFF with in_valid held
    bus.in_hdr   = 1'b0;
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'hFF;
    n1 = 0; n2 = 0; idle = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (s_busy) begin
        if (idle == 0) n1++;
        else           n2++;
      end else begin
        if (n2 > 0) break;
        idle++;
      end
      if (n2 > 0) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("b2b_first",  n1,   176);
    chk("b2b_idle",   idle, 1);
    chk("b2b_second", n2,   176);

    // motor pause of 37 clocks at clock 20 of a 0x00 byte
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      motor = (n >= 20 && n < 57) ? 1'b0 : 1'b1;
      tick();
      if (!s_busy) break;
      n++;
    end
    motor = 1'b1;
    chk("pause_dur", n, 213);

    // reset in the tone part of a long header
    bus.in_hdr   = 1'b1;
    bus.in_data  = 8'h01;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (26) tick();
    #1;
    chk("pre_rst_audio", int'(cas_audio), 1);
    rst = 1'b1;
    #1;
    chk("midrst_audio", int'(cas_audio),    0);
    chk("midrst_busy",  int'(busy),         0);
    chk("midrst_ready", int'(bus.in_ready), 1);
    mq.delete();
    m_busy = 0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    run_item(1'b0, 8'h00, 1'b0, n);
    chk("post_rst_dur", n, 176);

    // randomized traffic with motor drops against the model
    for (int k = 0; k < 20000; k++) begin
      motor        = ($urandom_range(0, 7) != 0);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_hdr   = ($urandom_range(0, 3) == 0);
      bus.in_data  = 8'($urandom);
      t_turbo      = $urandom_range(0, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cas_fsk_player.md
# cas_fsk_player

Cassette tape transmitter for the MSX1 core: turns a byte stream from the cassette image loader into the MSX 1200-baud FSK audio level that the machine's cassette input samples (PSG port A bit 7). It sits between the SDRAM/ioctl cassette buffer and the `cas_audio_in` net. It obeys the PPI port C bit 4 motor line, so BIOS tape routines start and stop playback exactly as with a real recorder.

## Interface
Parameters:
- `HALF_DIV`, 4474: clk cycles per half-period of the 2400 Hz tone (21.477 MHz / 4800).
- `SIL_HALVES`, 4800: silence before a long header, in units of `HALF_DIV` clocks (1 s).
- `LONG_CYC`, 16000: 2400 Hz cycles in a long header.
- `SHORT_CYC`, 4000: 2400 Hz cycles in a short header.

Ports:
- `clk` in 1: system clock. One clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `motor` in 1: cassette motor, from PPI port C bit 4. 1 = run.
- `in_valid` in 1: upstream item valid.
- `in_ready` out 1: block accepts an item on this edge.
- `in_hdr` in 1: 1 = header item, 0 = data byte.
- `in_data` in 8: data byte. For a header item, bit 0 = long (1) or short (0).
- `turbo` in 1: 2400-baud select. Only present and used with `CAS_TURBO_EN`.
- `cas_audio` out 1: FSK audio level.
- `busy` out 1: item in progress, including while paused.

## Operation
- States: IDLE, SILENCE, HEADER, DATA.
- Transfer happens when `in_valid & in_ready` on a clk edge. `in_ready = (state==IDLE) & motor`.
- On transfer:
  - Data item: latch the 11-bit frame. Start bit 0, then `in_data` LSB first, then two stop bits 1. Go to DATA with bit index 0.
  - Header item with bit0=1: go to SILENCE, then HEADER with `LONG_CYC`.
  - Header item with bit0=0: go directly to HEADER with `SHORT_CYC`.
- Bit encoding: every bit lasts 4·H clocks (H = `HALF_DIV`), and every bit starts with a high half.
  - 0 bit: one 1200 Hz cycle, i.e. high 2H, low 2H.
  - 1 bit: two 2400 Hz cycles, i.e. high H, low H, high H, low H.
- Header: N cycles of 2400 Hz, each high H then low H.
- SILENCE: `cas_audio`=0 for `SIL_HALVES`·H clocks.
- Counters:
  - Half-period counter: 15 bits, counts down.
  - Cycle/half counter: 16 bits.
  - Bit index: 4 bits, 0..10.
- Returns to IDLE after the last low half of the item. `cas_audio` is 0 in IDLE.
- Motor low: all counters and state are frozen, `cas_audio` is forced 0, and `in_ready` is 0. When motor goes high again, the frozen level and count resume exactly.
- `busy` = (state != IDLE).
- Reset (any time, including mid-item): state IDLE, all counters 0, `cas_audio`=0, `busy`=0, `in_ready`=`motor`. A partially sent item is discarded.
- `in_data`/`in_hdr` are sampled only on the transfer edge. Changes while not ready are ignored.

## Timing
- Transfer at edge N: `cas_audio` goes high from cycle N+1 (for SILENCE, stays 0).
- Data item occupies exactly 44·H clocks. `in_ready` rises on the cycle after the last low half.
- Back-to-back items with `in_valid` held high: exactly one IDLE cycle between items (output low, so the waveform is continuous).
- Long header item: (`SIL_HALVES` + 2·`LONG_CYC`)·H clocks. Short header item: 2·`SHORT_CYC`·H clocks.
- Motor-low cycles add exactly their count to item duration. No cycle is lost or duplicated at pause or resume.
- Motor falling on the same edge as a would-be transfer: no transfer occurs (`in_ready` already 0 combinationally).

## Configuration
- `CAS_TURBO_EN` defined:
  - The `turbo` port exists and is sampled at each transfer.
  - Items accepted with `turbo`=1 use half-period `HALF_DIV/2` (integer floor): 2400 baud, 2400/4800 Hz tones.
  - Data item then lasts 44·(H/2) clocks. Silence and header counts are unchanged in halves.
- `CAS_TURBO_EN` undefined: no `turbo` port. All items use `HALF_DIV`.

## Test plan
Bench parameters: `HALF_DIV`=4, `SIL_HALVES`=6, `LONG_CYC`=3, `SHORT_CYC`=2.
- Reset with `motor`=1, then data 0x00 -> 9 bits of high 8/low 8, then 2 bits of (high 4, low 4)×2. Total 176 clocks; `in_ready` returns at clock 177.
- Data 0xA5 back-to-back with 0xFF, `in_valid` held -> LSB-first pattern 0,1,0,1,0,0,1,0,1,1,1, then a single idle cycle, then the 0xFF frame.
- Long header (`in_hdr`=1, data 0x01) -> 24 clocks low, then 3 cycles of high 4/low 4. `busy` high for 48 clocks.
- Drop `motor` for 37 clocks at clock 20 of a 0x00 byte -> `cas_audio`=0 and `in_ready`=0 during the pause. The waveform resumes at the same phase; total duration 213 clocks.
- Assert `reset` mid-header -> `cas_audio`=0, `busy`=0 immediately. The next data item starts cleanly.
- With `CAS_TURBO_EN`, data 0x00 with `turbo`=1 -> 0 bits are high 4/low 4; byte lasts 88 clocks.
